// File: rtl/alu_sequencer.sv
// alu_sequencer: single-issue front end for the 16-bit ALU.
// Reads operands from an 8x16 register file, issues, waits, writes back.
module alu_sequencer #(
  parameter int ALU_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic        ld_en,
  input  logic [2:0]  ld_addr,
  input  logic [15:0] ld_data,
  input  logic [2:0]  rd_addr,
  output logic [15:0] rd_data,
  output logic [15:0] A,
  output logic [15:0] B,
  output logic [4:0]  operator,
  output logic        incoming,
  input  logic [15:0] Y,
  input  logic        carry,
  input  logic        signov,
  output logic        done,
  output logic        illegal,
  output logic        flag_c,
  output logic        flag_v,
  output logic        flag_z
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    WB
  } state_t;

  localparam logic [4:0] OP_ADD = 5'd0;
  localparam logic [4:0] OP_SUB = 5'd1;
  localparam logic [4:0] OP_SHL = 5'd7;

  localparam logic [2:0] WAIT_INIT =
    3'(ALU_LAT > 1 ? ALU_LAT - 2 : 0);

  state_t      state;
  state_t      state_nx;
  logic [2:0]  cnt;
  logic [2:0]  rd_q;
  logic [15:0] rf [8];

  logic [4:0]  opc;
  logic [2:0]  f_rd;
  logic [2:0]  f_ra;
  logic [2:0]  f_rb;
  logic        legal;
  logic        accept;
  logic        unused_bits;

  assign opc  = instr[15:11];
  assign f_rd = instr[10:8];
  assign f_ra = instr[7:5];
  assign f_rb = instr[4:2];
  assign unused_bits = ^instr[1:0];

  assign legal  = (opc <= 5'd5) ||
                  (opc >= 5'd7 && opc <= 5'd10);
  assign accept = instr_valid && (state == IDLE);

  assign rd_data = (rd_addr == 3'd0) ? 16'h0 : rf[rd_addr];

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // next state and state-decoded strobes
  always_comb begin
    state_nx    = state;
    instr_ready = 1'b0;
    incoming    = 1'b0;
    done        = 1'b0;
    unique case (state)
      IDLE: begin
        instr_ready = 1'b1;
        if (accept && legal) state_nx = ISSUE;
      end
      ISSUE: begin
        incoming = 1'b1;
        state_nx = (ALU_LAT > 1) ? WAIT : WB;
      end
      WAIT: begin
        if (cnt == 3'd0) state_nx = WB;
      end
      WB: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // ALU latency countdown, loaded on issue
  always_ff @(posedge clk) begin
    if (rst)                           cnt <= 3'd0;
    else if (state == ISSUE)           cnt <= WAIT_INIT;
    else if (state == WAIT && cnt != 0) cnt <= cnt - 3'd1;
  end

  // operand capture, register file, flags; WB write is last so it wins
  always_ff @(posedge clk) begin
    if (rst) begin
      A        <= 16'h0;
      B        <= 16'h0;
      operator <= 5'd0;
      rd_q     <= 3'd0;
      illegal  <= 1'b0;
      flag_c   <= 1'b0;
      flag_v   <= 1'b0;
      flag_z   <= 1'b0;
      for (int i = 0; i < 8; i++) rf[i[2:0]] <= 16'h0;
    end else begin
      if (accept && legal) begin
        A        <= rf[f_ra];
        B        <= rf[f_rb];
        operator <= opc;
        rd_q     <= f_rd;
      end
      if (accept && !legal) illegal <= 1'b1;
      if (ld_en && ld_addr != 3'd0) rf[ld_addr] <= ld_data;
      if (state == WB) begin
        if (rd_q != 3'd0) rf[rd_q] <= Y;
        flag_z <= (Y == 16'h0);
        if (operator == OP_ADD || operator == OP_SUB ||
            operator == OP_SHL)
          flag_c <= carry;
        if (operator == OP_ADD || operator == OP_SUB)
          flag_v <= signov;
      end
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed checks on two instances,
// ALU_LAT=1 (u1) and ALU_LAT=3 (u3), with a behavioural ALU each.
module tb_alu_sequencer;

  logic        clk;
  logic        rst;
  logic [15:0] instr;
  logic        instr_valid;
  logic        ld_en;
  logic [2:0]  ld_addr;
  logic [15:0] ld_data;
  logic [2:0]  rd_addr;

  logic        rdy1, inc1, done1, ill1, fc1, fv1, fz1, c1, v1;
  logic [15:0] rdd1, a1, b1, y1;
  logic [4:0]  op1;
  logic        rdy3, inc3, done3, ill3, fc3, fv3, fz3, c3, v3;
  logic [15:0] rdd3, a3, b3, y3;
  logic [4:0]  op3;

  int checks = 0;
  int errors = 0;

  alu_sequencer #(.ALU_LAT(1)) u1 (
    .clk(clk), .rst(rst), .instr(instr),
    .instr_valid(instr_valid), .instr_ready(rdy1),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .rd_addr(rd_addr), .rd_data(rdd1),
    .A(a1), .B(b1), .operator(op1), .incoming(inc1),
    .Y(y1), .carry(c1), .signov(v1),
    .done(done1), .illegal(ill1),
    .flag_c(fc1), .flag_v(fv1), .flag_z(fz1)
  );

  alu_sequencer #(.ALU_LAT(3)) u3 (
    .clk(clk), .rst(rst), .instr(instr),
    .instr_valid(instr_valid), .instr_ready(rdy3),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .rd_addr(rd_addr), .rd_data(rdd3),
    .A(a3), .B(b3), .operator(op3), .incoming(inc3),
    .Y(y3), .carry(c3), .signov(v3),
    .done(done3), .illegal(ill3),
    .flag_c(fc3), .flag_v(fv3), .flag_z(fz3)
  );

  function automatic logic [17:0] alu(
    input logic [4:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    logic [15:0] y;
    logic c, v;
    s = 17'h0; y = 16'h0; c = 1'b0; v = 1'b0;
    case (op)
      5'd0: begin
        s = {1'b0, a} + {1'b0, b}; y = s[15:0]; c = s[16];
        v = (a[15] == b[15]) && (y[15] != a[15]);
      end
      5'd1: begin
        s = {1'b0, a} - {1'b0, b}; y = s[15:0]; c = s[16];
        v = (a[15] != b[15]) && (y[15] != a[15]);
      end
      5'd2: y = a & b;
      5'd3: y = a | b;
      5'd4: y = ~a;
      5'd5: y = a ^ b;
      5'd7: begin y = a << 1; c = a[15]; end
      5'd8: y = a >> 1;
      5'd9: y = {15'h0, a < b};
      5'd10: y = {15'h0, a == b};
      default: y = 16'h0;
    endcase
    return {c, v, y};
  endfunction

  always_comb {c1, v1, y1} = alu(op1, a1, b1);
  always_comb {c3, v3, y3} = alu(op3, a3, b3);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rdchk(input string tag, input logic [2:0] addr,
                       input logic [15:0] e1, input logic [15:0] e3);
    rd_addr = addr;
    #1;
    chk({tag, "_u1"}, rdd1, e1);
    chk({tag, "_u3"}, rdd3, e3);
  endtask

  task automatic ld(input logic [2:0] addr, input logic [15:0] data);
    ld_en = 1'b1; ld_addr = addr; ld_data = data;
    tick();
    ld_en = 1'b0;
  endtask

  task automatic issue(input logic [4:0] op, input logic [2:0] rd,
                       input logic [2:0] ra, input logic [2:0] rb);
    instr = {op, rd, ra, rb, 2'b00};
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; instr = 16'h0; instr_valid = 1'b0;
    ld_en = 1'b0; ld_addr = 3'd0; ld_data = 16'h0; rd_addr = 3'd0;
    tick(); tick();
    chk("rst_ready", {15'h0, rdy1}, 16'h1);
    chk("rst_A", a1, 16'h0);
    chk("rst_op", {11'h0, op1}, 16'h0);
    chk("rst_strobes", {12'h0, inc1, done1, ill1, inc3}, 16'h0);
    chk("rst_flags", {13'h0, fc1, fv1, fz1}, 16'h0);
    rdchk("rst_rd1", 3'd1, 16'h0, 16'h0);
    rst = 1'b0;

    // add with carry out and zero result
    ld(3'd1, 16'hFFFF);
    ld(3'd2, 16'h0001);
    ld(3'd3, 16'h5555);
    rdchk("ld_r1", 3'd1, 16'hFFFF, 16'hFFFF);
    issue(5'd0, 3'd3, 3'd1, 3'd2);
    chk("add_inc1", {15'h0, inc1}, 16'h1);
    chk("add_inc3", {15'h0, inc3}, 16'h1);
    chk("add_busy1", {15'h0, rdy1}, 16'h0);
    chk("add_A", a1, 16'hFFFF);
    chk("add_B", b1, 16'h0001);
    tick();
    chk("add_done1", {15'h0, done1}, 16'h1);
    chk("add_inc1_off", {15'h0, inc1}, 16'h0);
    chk("add_done3_early", {15'h0, done3}, 16'h0);
    tick();
    chk("add_ready1", {15'h0, rdy1}, 16'h1);
    chk("add_c1", {15'h0, fc1}, 16'h1);
    chk("add_z1", {15'h0, fz1}, 16'h1);
    chk("add_done3_t3", {15'h0, done3}, 16'h0);
    rdchk("add_r3_t3", 3'd3, 16'h0000, 16'h5555);
    tick();
    chk("add_done3", {15'h0, done3}, 16'h1);
    tick();
    chk("add_ready3", {15'h0, rdy3}, 16'h1);
    chk("add_c3z3", {14'h0, fc3, fz3}, 16'h3);
    rdchk("add_r3", 3'd3, 16'h0000, 16'h0000);

    // signed overflow on sub
    ld(3'd1, 16'h8000);
    issue(5'd1, 3'd4, 3'd1, 3'd2);
    repeat (4) tick();
    rdchk("sub_r4", 3'd4, 16'h7FFF, 16'h7FFF);
    chk("sub_cvz1", {13'h0, fc1, fv1, fz1}, 16'h2);
    chk("sub_cvz3", {13'h0, fc3, fv3, fz3}, 16'h2);

    // illegal opcode, then write to r0
    issue(5'd6, 3'd5, 3'd1, 3'd2);
    chk("ill_flag", {14'h0, ill1, ill3}, 16'h3);
    chk("ill_no_inc", {14'h0, inc1, inc3}, 16'h0);
    chk("ill_ready", {14'h0, rdy1, rdy3}, 16'h3);
    tick();
    chk("ill_no_done", {14'h0, done1, done3}, 16'h0);
    rdchk("ill_r5", 3'd5, 16'h0, 16'h0);
    issue(5'd5, 3'd0, 3'd1, 3'd2);
    chk("xor_inc1", {15'h0, inc1}, 16'h1);
    tick();
    chk("xor_done1", {15'h0, done1}, 16'h1);
    tick(); tick();
    chk("xor_done3", {15'h0, done3}, 16'h1);
    tick();
    rdchk("xor_r0", 3'd0, 16'h0, 16'h0);
    chk("xor_cvz1", {13'h0, fc1, fv1, fz1}, 16'h2);
    chk("ill_sticky", {14'h0, ill1, ill3}, 16'h3);

    // reset while u3 is in WAIT
    issue(5'd0, 3'd6, 3'd1, 3'd2);
    chk("mid_inc3", {15'h0, inc3}, 16'h1);
    tick();
    rst = 1'b1;
    tick();
    chk("mid_no_done3", {15'h0, done3}, 16'h0);
    chk("mid_ready3", {15'h0, rdy3}, 16'h1);
    tick();
    chk("mid_A3", a3, 16'h0);
    chk("mid_B3", b3, 16'h0);
    chk("mid_ill", {14'h0, ill1, ill3}, 16'h0);
    chk("mid_flags3", {13'h0, fc3, fv3, fz3}, 16'h0);
    rdchk("mid_r1", 3'd1, 16'h0, 16'h0);
    rst = 1'b0;
    tick();
    chk("mid_post_ready", {14'h0, rdy1, rdy3}, 16'h3);
    tick();
    chk("mid_post_done", {14'h0, done1, done3}, 16'h0);
    rdchk("mid_r6", 3'd6, 16'h0, 16'h0);

    // load/writeback collision, same address, on u1
    ld(3'd1, 16'hABCD);
    issue(5'd3, 3'd5, 3'd1, 3'd2);
    tick();
    ld_en = 1'b1; ld_addr = 3'd5; ld_data = 16'h1234;
    tick();
    ld_en = 1'b0;
    rdchk("col_same", 3'd5, 16'hABCD, 16'h1234);
    tick(); tick();
    rdchk("col_same_late", 3'd5, 16'hABCD, 16'hABCD);

    // collision with a different load address
    issue(5'd3, 3'd5, 3'd1, 3'd2);
    tick();
    ld_en = 1'b1; ld_addr = 3'd6; ld_data = 16'h1234;
    tick();
    ld_en = 1'b0;
    rdchk("col_diff_r5", 3'd5, 16'hABCD, 16'hABCD);
    rdchk("col_diff_r6", 3'd6, 16'h1234, 16'h1234);
    tick(); tick();

    // same-address collision on u3
    ld(3'd5, 16'h0000);
    issue(5'd3, 3'd5, 3'd1, 3'd2);
    tick(); tick(); tick();
    chk("col3_wb", {15'h0, done3}, 16'h1);
    ld_en = 1'b1; ld_addr = 3'd5; ld_data = 16'h1234;
    tick();
    ld_en = 1'b0;
    rdchk("col3_r5", 3'd5, 16'h1234, 16'hABCD);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Upstream issue/writeback stage for the 16-bit ALU. Accepts 16-bit instruction words over a valid/ready handshake and reads operands from an internal 8×16 register file. Drives the ALU operand/operator inputs, waits the ALU latency, then writes the ALU result back and updates the C/V/Z flag register. Executes one instruction at a time and sits between the fetch logic and the ALU.

## Interface
Parameters:
- ALU_LAT, 1, cycles from the ALU issue cycle to valid Y/carry/signov; legal range 1..7.

Ports:
- clk  in  1  single clock for the whole block.
- rst  in  1  reset, synchronous and active-high, sampled on the rising edge of clk.
- instr  in  16  instruction word: [15:11] opcode, [10:8] rd, [7:5] ra, [4:2] rb, [1:0] ignored.
- instr_valid  in  1  instr is valid this cycle.
- instr_ready  out  1  block can accept an instruction (IDLE state).
- ld_en  in  1  external register load strobe.
- ld_addr  in  3  external load address.
- ld_data  in  16  external load data.
- rd_addr  in  3  debug read address.
- rd_data  out  16  combinational read of reg[rd_addr].
- A  out  16  ALU operand A, registered.
- B  out  16  ALU operand B, registered.
- operator  out  5  ALU opcode, registered; copied from instr[15:11].
- incoming  out  1  one-cycle issue strobe to the ALU.
- Y  in  16  ALU result.
- carry  in  1  ALU carry out.
- signov  in  1  ALU signed overflow.
- done  out  1  one-cycle pulse in the writeback cycle.
- illegal  out  1  sticky illegal-opcode flag; cleared only by rst.
- flag_c  out  1  carry flag.
- flag_v  out  1  overflow flag.
- flag_z  out  1  zero flag.

## Operation
- Legal opcodes: 0 add, 1 sub, 2 and, 3 or, 4 not, 5 xor, 7 shl, 8 shr, 9 lt, 10 eq. Opcodes 6 and 11–31 are illegal.
- FSM states: IDLE, ISSUE, WAIT, WB.
  - IDLE: instr_ready=1. An instruction is accepted when instr_valid && instr_ready.
    - Legal opcode: capture A=reg[ra], B=reg[rb], operator=opcode and rd, then go to ISSUE.
    - Illegal opcode: set illegal, stay in IDLE, no issue, no writeback, done stays 0.
  - ISSUE: incoming=1 for exactly this cycle. Go to WAIT if ALU_LAT>1, else to WB.
  - WAIT: a 3-bit counter holds this state for ALU_LAT−1 cycles, then goes to WB.
  - WB: sample Y, carry and signov; write Y to reg[rd]; done=1; update flags; go to IDLE.
- Register 0 always reads 0. Writes to r0 from WB or ld_en are discarded.
- Flag update in WB:
  - flag_z = (Y==0) for every legal op.
  - flag_c = carry for add, sub and shl; unchanged otherwise.
  - flag_v = signov for add and sub; unchanged otherwise.
- A, B and operator hold stable from ISSUE through WB. They keep their last value in IDLE.
- ld_en writes reg[ld_addr]=ld_data in any state.
  - If ld_en and the WB write target the same address in the same cycle, WB wins.
  - Writes to different addresses in the same cycle both take effect.
- rd_data shows a written value from the cycle after the write edge (no bypass).
- Instructions are fully serialized, so there are no operand hazards.
- rst in any state, including mid-WAIT:
  - FSM goes to IDLE and the pending writeback is dropped.
  - All registers and flags are cleared to 0.

## Timing
- Reset values: instr_ready=1, A=0, B=0, operator=0, incoming=0, done=0, illegal=0, flag_c=flag_v=flag_z=0, all regs 0, rd_data=0.
- For an instruction accepted at cycle T:
  - incoming=1 at T+1.
  - WB and done at T+1+ALU_LAT.
  - Register and flag values visible, and instr_ready=1 again, at T+2+ALU_LAT.
- Throughput is one instruction per ALU_LAT+2 cycles.
- An illegal opcode accepted at T sets illegal visible at T+1. instr_ready stays 1.
- instr_valid while instr_ready=0 is ignored. The source must hold instr until it is accepted.

## Test plan
- Reset: assert rst 2 cycles mid-stream -> every output at its reset value, instr_ready=1 on the following cycle.
- Add carry/zero (ALU_LAT=1): ld r1=0xFFFF, r2=0x0001; issue add rd=3, ra=1, rb=2 -> incoming at T+1, done at T+2; r3=0x0000, flag_c=1, flag_z=1.
- Signed overflow: r1=0x8000, r2=0x0001; sub rd=4 -> r4=0x7FFF, flag_v=1 (from ALU signov), flag_z=0.
- Illegal and r0: opcode 6 -> illegal=1, no incoming, no done, regs unchanged. Then xor rd=0 -> done pulses, reg0 still reads 0.
- Reset mid-WAIT (ALU_LAT=3): rst asserted the cycle after ISSUE -> no done pulse, rd unchanged (0), IDLE on the next cycle.
- Load/WB collision: ld_en to r5 (0x1234) in the same cycle as WB to r5 (0xABCD) -> r5=0xABCD. The same collision with ld to r6 -> r5=0xABCD and r6=0x1234.
